// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter onto a single-beat AXI4 memory master.
// One transaction outstanding at a time; responses are routed back by grant index.
module mem_req_arbiter #(
    parameter int unsigned AXI_WIDTH_ADDR = 32,
    parameter int unsigned AXI_WIDTH_DATA = 32
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_we,
    input  logic [2*AXI_WIDTH_ADDR-1:0]   req_addr,
    input  logic [2*AXI_WIDTH_DATA-1:0]   req_wdata,
    input  logic [2*AXI_WIDTH_DATA/8-1:0] req_wstrb,
    output logic [1:0]                    rsp_valid,
    output logic [AXI_WIDTH_DATA-1:0]     rsp_rdata,
    output logic                          rsp_err,
    output logic [AXI_WIDTH_ADDR-1:0]     m_axi_mem_awaddr,
    output logic                          m_axi_mem_awvalid,
    input  logic                          m_axi_mem_awready,
    output logic [AXI_WIDTH_DATA-1:0]     m_axi_mem_wdata,
    output logic [AXI_WIDTH_DATA/8-1:0]   m_axi_mem_wstrb,
    output logic                          m_axi_mem_wvalid,
    input  logic                          m_axi_mem_wready,
    input  logic [1:0]                    m_axi_mem_bresp,
    input  logic                          m_axi_mem_bvalid,
    output logic                          m_axi_mem_bready,
    output logic [AXI_WIDTH_ADDR-1:0]     m_axi_mem_araddr,
    output logic                          m_axi_mem_arvalid,
    input  logic                          m_axi_mem_arready,
    input  logic [AXI_WIDTH_DATA-1:0]     m_axi_mem_rdata,
    input  logic [1:0]                    m_axi_mem_rresp,
    input  logic                          m_axi_mem_rvalid,
    output logic                          m_axi_mem_rready
);

    localparam int unsigned AW = AXI_WIDTH_ADDR;
    localparam int unsigned DW = AXI_WIDTH_DATA;
    localparam int unsigned SW = AXI_WIDTH_DATA / 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_BRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    logic [2:0]    r_state;
    logic          r_gnt;
    logic          r_last;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;
    logic [1:0]    r_rsp_valid;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_err;

    logic [2:0]    w_state_nxt;
    logic          w_awvalid_nxt;
    logic          w_wvalid_nxt;
    logic          w_bready_nxt;
    logic          w_arvalid_nxt;
    logic          w_rready_nxt;
    logic [1:0]    w_rsp_valid_nxt;
    logic [DW-1:0] w_rsp_rdata_nxt;
    logic          w_rsp_err_nxt;
    logic          w_grant;
    logic [1:0]    w_req_ready;
    logic [1:0]    w_rsp_sel;
    logic          w_gnt;
    logic          w_req_we;
    logic          w_unused;

    // Both pending: favour whoever was not granted last; otherwise the lone requester.
    assign w_gnt    = (&req_valid) ? ~r_last : req_valid[1];
    assign w_req_we = w_gnt ? req_we[1] : req_we[0];
    assign w_unused = &{1'b0, m_axi_mem_bresp[0], m_axi_mem_rresp[0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = 1'b0;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = 1'b0;
        w_rsp_valid_nxt = 2'b00;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_grant         = 1'b0;
        w_req_ready     = 2'b00;
        w_rsp_sel       = r_gnt ? 2'b10 : 2'b01;
        case (r_state)
            S_IDLE: begin
                // A response pulse blocks arbitration for that cycle.
                if ((r_rsp_valid == 2'b00) && (|req_valid)) begin
                    w_grant     = 1'b1;
                    w_req_ready = w_gnt ? 2'b10 : 2'b01;
                    if (w_req_we) begin
                        w_state_nxt   = S_WRITE;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_READ;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (m_axi_mem_awready) w_awvalid_nxt = 1'b0;
                if (m_axi_mem_wready)  w_wvalid_nxt  = 1'b0;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_state_nxt  = S_BRESP;
                    w_bready_nxt = 1'b1;
                end
            end
            S_BRESP: begin
                if (m_axi_mem_bvalid) begin
                    w_rsp_valid_nxt = w_rsp_sel;
                    w_rsp_err_nxt   = m_axi_mem_bresp[1];
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_bready_nxt = 1'b1;
                end
            end
            S_READ: begin
                if (m_axi_mem_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_axi_mem_rvalid) begin
                    w_rsp_valid_nxt = w_rsp_sel;
                    w_rsp_rdata_nxt = m_axi_mem_rdata;
                    w_rsp_err_nxt   = m_axi_mem_rresp[1];
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_rready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Request payload is captured at grant so requesters may move on immediately.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_grant) begin
            r_gnt   <= w_gnt;
            r_last  <= w_gnt;
            r_addr  <= w_gnt ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
            r_wdata <= w_gnt ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
            r_wstrb <= w_gnt ? req_wstrb[2*SW-1:SW] : req_wstrb[SW-1:0];
        end
    end

    assign req_ready         = w_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_rdata         = r_rsp_rdata;
    assign rsp_err           = r_rsp_err;
    assign m_axi_mem_awaddr  = r_addr;
    assign m_axi_mem_awvalid = r_awvalid;
    assign m_axi_mem_wdata   = r_wdata;
    assign m_axi_mem_wstrb   = r_wstrb;
    assign m_axi_mem_wvalid  = r_wvalid;
    assign m_axi_mem_bready  = r_bready;
    assign m_axi_mem_araddr  = r_addr;
    assign m_axi_mem_arvalid = r_arvalid;
    assign m_axi_mem_rready  = r_rready;

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameters SHALL be: AXI_WIDTH_ADDR, default 32, address width; AXI_WIDTH_DATA, default 32, data width (only 32 supported).
REQ-002 Clocking SHALL be one clock, axi_aclk; reset axi_aresetn SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be (name direction width meaning):
- axi_aclk  in  1  clock
- axi_aresetn  in  1  async active-low reset
- req_valid  in  2  request pending, bit i = requester i
- req_ready  out  2  request accepted, one-cycle pulse
- req_we  in  2  1 = write, 0 = read
- req_addr  in  64  packed addresses, requester i at [32i+31:32i]
- req_wdata  in  64  packed write data
- req_wstrb  in  8  packed byte strobes, requester i at [4i+3:4i]
- rsp_valid  out  2  response pulse to requester i
- rsp_rdata  out  32  read data, shared
- rsp_err  out  1  response error, valid with rsp_valid
- m_axi_mem_awaddr  out  32  write address
- m_axi_mem_awvalid  out  1  write address valid
- m_axi_mem_awready  in  1  write address ready
- m_axi_mem_wdata  out  32  write data
- m_axi_mem_wstrb  out  4  write strobes
- m_axi_mem_wvalid  out  1  write data valid
- m_axi_mem_wready  in  1  write data ready
- m_axi_mem_bresp  in  2  write response
- m_axi_mem_bvalid  in  1  write response valid
- m_axi_mem_bready  out  1  write response ready
- m_axi_mem_araddr  out  32  read address
- m_axi_mem_arvalid  out  1  read address valid
- m_axi_mem_arready  in  1  read address ready
- m_axi_mem_rdata  in  32  read data
- m_axi_mem_rresp  in  2  read response
- m_axi_mem_rvalid  in  1  read data valid
- m_axi_mem_rready  out  1  read data ready
REQ-004 ID, len, size, burst and wlast fields SHALL be tied by the integrator to 0/0/3'b010/INCR/1; all transactions are single-beat.

Function
REQ-005 FSM states SHALL be IDLE, WRITE, BRESP, READ and RDATA; at most one transaction SHALL be outstanding.
REQ-006 Arbitration in IDLE: one valid requester wins; when both are valid, the winner SHALL be the requester not granted last (round-robin).
REQ-007 On the grant, req_ready[g] SHALL be high for exactly that IDLE cycle; addr, wdata, wstrb and we SHALL be registered; inputs may change afterwards.
REQ-008 Write path: WRITE SHALL assert awvalid and wvalid together on the cycle after acceptance; each SHALL drop after its own handshake; when both are done, go to BRESP.
REQ-009 BRESP SHALL hold bready=1; on bvalid: rsp_valid[g]=1 for one cycle, rsp_err=bresp[1], return to IDLE.
REQ-010 Read path: READ SHALL hold arvalid until arready, then go to RDATA with rready=1; on rvalid: capture rdata into rsp_rdata, pulse rsp_valid[g], rsp_err=rresp[1], return to IDLE.
REQ-011 rsp_rdata and rsp_err SHALL hold their value until the next response.
REQ-012 Latency with a zero-wait slave: accept at cycle 0, addr/data valid at cycle 1, rsp_valid at cycle 3 (write) or cycle 3 (read).
REQ-013 AXI valids SHALL NOT depend combinationally on any ready; valid SHALL NOT drop before its handshake.
REQ-014 wstrb=0 writes SHALL still be issued unchanged.
REQ-015 No new grant SHALL be issued in the cycle a response pulses; the next arbitration happens in IDLE of the following cycle.

Reset
REQ-016 Asserting axi_aresetn low SHALL immediately force IDLE, all valid/ready/rsp outputs to 0, rsp_rdata to 0, rsp_err to 0, and the round-robin pointer to favour requester 0.
REQ-017 Reset mid-transaction SHALL abandon the transaction with no response pulse.

Verification
REQ-018 Single read: req0 read of 0x0000_0100 with slave rdata 0xDEADBEEF, rresp 0 -> araddr 0x100, rsp_valid=2'b01, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-019 Contention: both requesters valid for four transactions -> grants alternate 0,1,0,1; req_ready is never 2'b11.
REQ-020 Split handshake: write to 0x200 with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one AW and one W beat.
REQ-021 Error: req1 write with bresp=2'b10 -> rsp_valid=2'b10 and rsp_err=1; the next OKAY read returns rsp_err=0.
REQ-022 Reset in RDATA: no rsp_valid is pulsed, outputs go to 0; after release with both requesters valid, requester 0 wins first.
